// File: rtl/aes_gcm_ingress_framer.sv
// aes_gcm_ingress_framer
// Front end of one AES-GCM worker. It parses a 128-bit word stream of the form
// key / IV+flag / sizes / AAD blocks / PT blocks. The header is held for the
// whole frame. Payload is presented one block per cycle, with a one-cycle
// o_new_instance pulse on block 0. Bit 0 of every bus is its MSB.
module aes_gcm_ingress_framer #(
  parameter int WORKER_ID  = 0,
  parameter int MAX_BLOCKS = 99999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [0:127] o_cipher_key,
  output logic [0:95]  o_iv,
  output logic [0:127] o_instance_size,
  output logic [0:127] o_aad,
  output logic [0:127] o_plain_text,
  output logic         o_new_instance,
  output logic         o_pt_instance,
  output logic [3:0]   o_id,
  output logic         o_busy,
  output logic         o_error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR_IV   = 3'd1,
    S_HDR_SIZE = 3'd2,
    S_CHECK    = 3'd3,
    S_STREAM   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [0:127] key_q,  key_d;
  logic [0:95]  iv_q,   iv_d;
  logic [0:127] size_q, size_d;
  logic         flag_q, flag_d;
  logic [63:0]  aad_blk_q,  aad_blk_d;
  logic [63:0]  last_blk_q, last_blk_d;
  logic [63:0]  blk_q,  blk_d;
  logic [0:127] aad_q,  aad_d;
  logic [0:127] pt_q,   pt_d;
  logic         new_q,  new_d;
  logic         err_q,  err_d;

  logic         accept;
  logic [63:0]  hdr_aad_blk;
  logic [63:0]  hdr_pt_blk;
  logic [64:0]  hdr_total;
  logic         hdr_bad;

  // Block counts are derived from the latched size word. The sum is 65 bits
  // wide, so two huge lengths cannot wrap around and slip past the limit.
  always_comb begin
    hdr_aad_blk = {7'd0, size_q[0:56]};
    hdr_pt_blk  = {7'd0, size_q[64:120]};
    hdr_total   = {1'b0, hdr_aad_blk} + {1'b0, hdr_pt_blk};
    hdr_bad     = (size_q[57:63] != 7'd0) ||
                  (size_q[121:127] != 7'd0) ||
                  (hdr_total == 65'd0) ||
                  (hdr_total > 65'(MAX_BLOCKS));
  end

  assign accept = s_valid && s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The FSM leaves STREAM early on underrun because
  // stage 1 counts blocks freely and cannot be held off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = S_HDR_IV;
      S_HDR_IV:   if (accept) state_d = S_HDR_SIZE;
      S_HDR_SIZE: if (accept) state_d = S_CHECK;
      S_CHECK:    state_d = hdr_bad ? S_IDLE : S_STREAM;
      S_STREAM: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (blk_q == last_blk_q) begin
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs. Ready is forced low while reset is held.
  always_comb begin
    s_ready = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      S_IDLE:     s_ready = !rst;
      S_HDR_IV:   begin s_ready = !rst; o_busy = 1'b1; end
      S_HDR_SIZE: begin s_ready = !rst; o_busy = 1'b1; end
      S_CHECK:    o_busy = 1'b1;
      S_STREAM:   begin s_ready = !rst; o_busy = 1'b1; end
      default:    begin s_ready = 1'b0; o_busy = 1'b0; end
    endcase
  end

  // Datapath next values. Header registers hold by default.
  // Payload buses and pulses return to zero unless a block is accepted.
  always_comb begin
    key_d      = key_q;
    iv_d       = iv_q;
    size_d     = size_q;
    flag_d     = flag_q;
    aad_blk_d  = aad_blk_q;
    last_blk_d = last_blk_q;
    blk_d      = blk_q;
    aad_d      = '0;
    pt_d       = '0;
    new_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) key_d = s_data;
      end
      S_HDR_IV: begin
        if (accept) begin
          iv_d   = s_data[0:95];
          flag_d = s_data[127];
        end
      end
      S_HDR_SIZE: begin
        if (accept) size_d = s_data;
      end
      S_CHECK: begin
        if (hdr_bad) begin
          err_d  = 1'b1;
          key_d  = '0;
          iv_d   = '0;
          size_d = '0;
          flag_d = 1'b0;
        end else begin
          aad_blk_d  = hdr_aad_blk;
          last_blk_d = hdr_total[63:0] - 64'd1;
          blk_d      = 64'd0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (blk_q < aad_blk_q) begin
            aad_d = s_data;
          end else begin
            pt_d = s_data;
          end
          new_d = (blk_q == 64'd0);
          blk_d = blk_q + 64'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  // Datapath registers. All of them clear on reset, so outputs drop at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      iv_q       <= '0;
      size_q     <= '0;
      flag_q     <= 1'b0;
      aad_blk_q  <= '0;
      last_blk_q <= '0;
      blk_q      <= '0;
      aad_q      <= '0;
      pt_q       <= '0;
      new_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      key_q      <= key_d;
      iv_q       <= iv_d;
      size_q     <= size_d;
      flag_q     <= flag_d;
      aad_blk_q  <= aad_blk_d;
      last_blk_q <= last_blk_d;
      blk_q      <= blk_d;
      aad_q      <= aad_d;
      pt_q       <= pt_d;
      new_q      <= new_d;
      err_q      <= err_d;
    end
  end

  assign o_cipher_key    = key_q;
  assign o_iv            = iv_q;
  assign o_instance_size = size_q;
  assign o_pt_instance   = flag_q;
  assign o_aad           = aad_q;
  assign o_plain_text    = pt_q;
  assign o_new_instance  = new_q;
  assign o_error         = err_q;
  assign o_id            = 4'(WORKER_ID);

endmodule

// File: tb/tb_aes_gcm_ingress_framer.sv
// Directed bench for aes_gcm_ingress_framer. Each driven cycle pushes the
// payload-side output expected one cycle later onto a scoreboard queue; the
// entry is popped and compared after the clock edge.
module tb_aes_gcm_ingress_framer;

  logic         clk;
  logic         rst;
  logic [0:127] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [0:127] o_cipher_key;
  logic [0:95]  o_iv;
  logic [0:127] o_instance_size;
  logic [0:127] o_aad;
  logic [0:127] o_plain_text;
  logic         o_new_instance;
  logic         o_pt_instance;
  logic [3:0]   o_id;
  logic         o_busy;
  logic         o_error;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [0:127] aad;
    logic [0:127] pt;
    logic         ni;
    logic         err;
  } exp_t;

  exp_t sb[$];

  aes_gcm_ingress_framer #(.WORKER_ID(2), .MAX_BLOCKS(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .o_cipher_key(o_cipher_key), .o_iv(o_iv), .o_instance_size(o_instance_size),
    .o_aad(o_aad), .o_plain_text(o_plain_text), .o_new_instance(o_new_instance),
    .o_pt_instance(o_pt_instance), .o_id(o_id), .o_busy(o_busy), .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the outputs expected after the edge.
  task automatic step(input logic v, input logic [0:127] d, input logic [0:127] ea,
                      input logic [0:127] ep, input logic eni, input logic eer);
    exp_t e;
    exp_t x;
    e.aad = ea; e.pt = ep; e.ni = eni; e.err = eer;
    sb.push_back(e);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("aad", o_aad, x.aad);
    chk("plain_text", o_plain_text, x.pt);
    chk1("new_instance", o_new_instance, x.ni);
    chk1("error", o_error, x.err);
  endtask

  // Three header words plus the CHECK cycle; bad selects a reject.
  task automatic header(input logic [0:127] k, input logic [0:95] v, input logic f,
                        input logic [63:0] al, input logic [63:0] pl, input logic bad);
    logic [0:127] w1;
    w1 = {v, 31'd0, f};
    step(1'b1, k, '0, '0, 1'b0, 1'b0);
    chk("key_latch", o_cipher_key, k);
    step(1'b1, w1, '0, '0, 1'b0, 1'b0);
    chk("iv_latch", {o_iv, 32'd0}, {v, 32'd0});
    chk1("flag_latch", o_pt_instance, f);
    step(1'b1, {al, pl}, '0, '0, 1'b0, 1'b0);
    chk("size_latch", o_instance_size, {al, pl});
    chk1("busy_hdr", o_busy, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, bad);
    if (bad) begin
      chk("key_cleared", o_cipher_key, '0);
      chk("iv_cleared", {o_iv, 32'd0}, '0);
      chk("size_cleared", o_instance_size, '0);
      chk1("flag_cleared", o_pt_instance, 1'b0);
      chk1("busy_reject", o_busy, 1'b0);
    end else begin
      chk1("busy_stream", o_busy, 1'b1);
      chk1("ready_stream", s_ready, 1'b1);
    end
  endtask

  task automatic pay(input logic [0:127] d, input logic is_aad, input logic first);
    step(1'b1, d, is_aad ? d : 128'd0, is_aad ? 128'd0 : d, first, 1'b0);
  endtask

  task automatic frame1();
    header(128'h000102030405060708090a0b0c0d0e0f, 96'hcafebabefacedbaddecaf888, 1'b1,
           64'd256, 64'd384, 1'b0);
    pay(128'ha0a0a0a0_00000000_11111111_a0a0a0a0, 1'b1, 1'b1);
    pay(128'ha1a1a1a1_22222222_33333333_a1a1a1a1, 1'b1, 1'b0);
    pay(128'hb0b0b0b0_44444444_55555555_b0b0b0b0, 1'b0, 1'b0);
    pay(128'hb1b1b1b1_66666666_77777777_b1b1b1b1, 1'b0, 1'b0);
    pay(128'hb2b2b2b2_88888888_99999999_b2b2b2b2, 1'b0, 1'b0);
    chk1("busy_after_frame", o_busy, 1'b0);
    chk("key_held", o_cipher_key, 128'h000102030405060708090a0b0c0d0e0f);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_aad", o_aad, '0);
    chk("rst_key", o_cipher_key, '0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_ready", s_ready, 1'b0);
    chk1("rst_error", o_error, 1'b0);
    chk("rst_id", {124'd0, o_id}, 128'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("ready_idle", s_ready, 1'b1);

    // 1: AAD + PT frame
    frame1();

    // 2: single PT block
    header(128'h11, 96'h22, 1'b0, 64'd0, 64'd128, 1'b0);
    pay(128'hdeadbeef, 1'b0, 1'b1);
    chk1("busy_single", o_busy, 1'b0);
    chk1("ready_single", s_ready, 1'b1);

    // 3: rejects (unaligned AAD, empty frame, over limit)
    header(128'h33, 96'h44, 1'b1, 64'd100, 64'd128, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    header(128'h55, 96'h66, 1'b1, 64'd0, 64'd0, 1'b1);
    header(128'h57, 96'h67, 1'b1, 64'd512, 64'd640, 1'b1);

    // limit boundary: exactly MAX_BLOCKS PT blocks is accepted
    header(128'h59, 96'h69, 1'b0, 64'd0, 64'd1024, 1'b0);
    for (int i = 0; i < 8; i++) pay(128'(i + 32'h100), 1'b0, i == 0);
    chk1("busy_limit", o_busy, 1'b0);

    // 4: underrun, then next word becomes a key
    header(128'h77, 96'h88, 1'b0, 64'd0, 64'd512, 1'b0);
    pay(128'hc0, 1'b0, 1'b1);
    pay(128'hc1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk1("busy_underrun", o_busy, 1'b0);
    header(128'hc2, 96'h99, 1'b0, 64'd0, 64'd128, 1'b0);
    pay(128'hc3, 1'b0, 1'b1);

    // 5: back-to-back frames
    header(128'haa, 96'hab, 1'b1, 64'd128, 64'd128, 1'b0);
    pay(128'hd0, 1'b1, 1'b1);
    pay(128'hd1, 1'b0, 1'b0);
    header(128'hbb, 96'hbc, 1'b0, 64'd0, 64'd256, 1'b0);
    pay(128'he0, 1'b0, 1'b1);
    pay(128'he1, 1'b0, 1'b0);

    // 6: asynchronous reset mid-stream
    header(128'hcc, 96'hcd, 1'b1, 64'd256, 64'd384, 1'b0);
    pay(128'hf0, 1'b1, 1'b1);
    pay(128'hf1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_aad", o_aad, '0);
    chk("arst_key", o_cipher_key, '0);
    chk1("arst_error", o_error, 1'b0);
    chk1("arst_busy", o_busy, 1'b0);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("arst_hold_error", o_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    frame1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
